// File: rtl/display_mux.sv
// display_mux -- output stage of the T3 datapath.
//
// Latches each 16-bit word qualified by data_valid and time-multiplexes it
// onto eight active-low 7-segment digits together with a source-module glyph
// and the current clock-program number. Also drives the even-parity bit of
// the held word and a per-word heartbeat on the decimal point of digit 0.
//
// Parameters:
//   REFRESH_DIV  clk cycles each digit stays selected (2..2^20)
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   data_valid  one-cycle qualifier for data
//   data[15:0]  word from the buffer
//   modules[1:0] source selector (1 = fibonacci 'F', 2 = timer 't', else '-')
//   prog[2:0]   current DCM program, shown as a decimal digit
//   an[7:0]     digit enables, active-low, one-hot-low (registered)
//   dec_ddp[7:0] segments a..g,dp on [7:0], active-low (registered)
//   parity      XOR of all bits of the held word
//
// Build option:
//   DM_LEADING_ZERO_BLANK_EN  blank leading zero data digits 3..1
//                             (digit 0 is always shown)

module display_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [15:0] data,
  input  logic [1:0]  modules,
  input  logic [2:0]  prog,
  output logic [7:0]  an,
  output logic [7:0]  dec_ddp,
  output logic        parity
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [15:0]      r_held;
  logic             r_parity;
  logic             r_hb;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic [7:0]       r_an;
  logic [7:0]       r_dec;

  logic [3:0]       w_nib;
  logic             w_lz_blank;
  logic [7:0]       w_an_nxt;
  logic [7:0]       w_dec_nxt;

  // Hex glyphs, segments a..g in [7:1], dp (bit 0) off.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'h03;  4'h1: hex7 = 8'h9F;
      4'h2: hex7 = 8'h25;  4'h3: hex7 = 8'h0D;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h49;
      4'h6: hex7 = 8'h41;  4'h7: hex7 = 8'h1F;
      4'h8: hex7 = 8'h01;  4'h9: hex7 = 8'h09;
      4'hA: hex7 = 8'h11;  4'hB: hex7 = 8'hC1;
      4'hC: hex7 = 8'h63;  4'hD: hex7 = 8'h85;
      4'hE: hex7 = 8'h61;  default: hex7 = 8'h71;
    endcase
  endfunction

  always_comb begin
    case (r_idx[1:0])
      2'd0:    w_nib = r_held[3:0];
      2'd1:    w_nib = r_held[7:4];
      2'd2:    w_nib = r_held[11:8];
      default: w_nib = r_held[15:12];
    endcase
  end

  // A data digit is blanked only while it and every higher digit are zero.
`ifdef DM_LEADING_ZERO_BLANK_EN
  always_comb begin
    case (r_idx[1:0])
      2'd1:    w_lz_blank = (r_held[15:4] == 12'h000);
      2'd2:    w_lz_blank = (r_held[15:8] == 8'h00);
      2'd3:    w_lz_blank = (r_held[15:12] == 4'h0);
      default: w_lz_blank = 1'b0;
    endcase
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_an_nxt  = 8'hFF;
    w_dec_nxt = 8'hFF;
    case (r_idx)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        if (!w_lz_blank) begin
          w_an_nxt  = ~(8'h01 << r_idx);
          w_dec_nxt = hex7(w_nib);
          // Heartbeat dp lives on digit 0 only.
          if (r_idx == 3'd0 && r_hb) w_dec_nxt[0] = 1'b0;
        end
      end
      3'd5: begin
        w_an_nxt = 8'hDF;
        case (modules)
          2'd1:    w_dec_nxt = 8'h71;
          2'd2:    w_dec_nxt = 8'hE1;
          default: w_dec_nxt = 8'hFD;
        endcase
      end
      3'd7: begin
        w_an_nxt  = 8'h7F;
        w_dec_nxt = hex7({1'b0, prog});
      end
      default: ;  // slots 4 and 6 stay dark
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held   <= '0;
      r_parity <= 1'b0;
      r_hb     <= 1'b0;
      r_div    <= '0;
      r_idx    <= '0;
      r_an     <= 8'hFF;
      r_dec    <= 8'hFF;
    end else begin
      if (data_valid) begin
        r_held   <= data;
        r_parity <= ^data;
        r_hb     <= ~r_hb;
      end
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_an  <= w_an_nxt;
      r_dec <= w_dec_nxt;
    end
  end

  assign an      = r_an;
  assign dec_ddp = r_dec;
  assign parity  = r_parity;

endmodule

// File: tb/tb_display_mux.sv
// Directed self-checking bench for display_mux with REFRESH_DIV = 4.
// Expected glyphs are hand-computed constants; the slot on display is
// tracked from the number of clock edges since reset release.

module tb_display_mux;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data;
  logic [1:0]  modules;
  logic [2:0]  prog;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;
  logic        parity;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [7:0] an_seq [8];

  display_mux #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .modules(modules), .prog(prog), .an(an), .dec_ddp(dec_ddp),
    .parity(parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge; sample point is 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc++;
    #1;
  endtask

  function automatic int slot_of(input int c);
    return ((c - 1) / RD) % 8;
  endfunction

  // Always advances at least one edge, then stops on the first edge
  // where slot s is on display.
  task automatic goto_slot(input int s);
    int k;
    k = 0;
    tick();
    while (slot_of(cyc) != s && k < 80) begin
      tick();
      k++;
    end
    if (slot_of(cyc) != s) chk("goto_timeout", 16'(slot_of(cyc)), 16'(s));
  endtask

  task automatic capture(input logic [15:0] w);
    data       = w;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic chk_slot(input int s, input logic [7:0] seg);
    goto_slot(s);
    chk($sformatf("an_s%0d", s), 16'(an), 16'(an_seq[s]));
    chk($sformatf("seg_s%0d", s), 16'(dec_ddp), 16'(seg));
  endtask

  task automatic chk_blank(input int s);
    goto_slot(s);
    chk($sformatf("blank_an_s%0d", s), 16'(an), 16'hFF);
    chk($sformatf("blank_seg_s%0d", s), 16'(dec_ddp), 16'hFF);
  endtask

  initial begin
    an_seq[0] = 8'hFE; an_seq[1] = 8'hFD; an_seq[2] = 8'hFB; an_seq[3] = 8'hF7;
    an_seq[4] = 8'hFF; an_seq[5] = 8'hDF; an_seq[6] = 8'hFF; an_seq[7] = 8'h7F;

    rst = 1'b1; data_valid = 1'b0; data = '0; modules = 2'd0; prog = 3'd0;
    // valid during reset must be ignored
    data_valid = 1'b1; data = 16'hFFFF;
    repeat (3) tick();
    data_valid = 1'b0;
    chk("rst_an", 16'(an), 16'hFF);
    chk("rst_seg", 16'(dec_ddp), 16'hFF);
    chk("rst_par", 16'(parity), 16'h0);

    // Scan period / sequence with held = 0
    rst = 1'b0;
    tick();
    chk("first_an", 16'(an), 16'hFE);
    chk("first_seg", 16'(dec_ddp), 16'h03);
    for (int n = 2; n <= 64; n++) begin
      tick();
`ifdef DM_LEADING_ZERO_BLANK_EN
      if (slot_of(cyc) >= 1 && slot_of(cyc) <= 3)
        chk($sformatf("scan_c%0d", cyc), 16'(an), 16'hFF);
      else
`endif
      chk($sformatf("scan_c%0d", cyc), 16'(an), 16'(an_seq[slot_of(cyc)]));
    end

    // Capture and parity
    modules = 2'd1; prog = 3'd5;
    capture(16'h1A2F);
    chk("par_1A2F", 16'(parity), 16'h0);
    chk_slot(0, 8'h70);
    chk_slot(1, 8'h25);
    chk_slot(2, 8'h11);
    chk_slot(3, 8'h9F);
    chk_blank(4);
    chk_slot(5, 8'h71);
    chk_blank(6);
    chk_slot(7, 8'h49);

    // Reset mid-operation
    capture(16'hBEEF);
    chk("par_BEEF", 16'(parity), 16'h1);
    chk_slot(3, 8'hC1);
    rst = 1'b1;
    tick();
    chk("midrst_an", 16'(an), 16'hFF);
    chk("midrst_seg", 16'(dec_ddp), 16'hFF);
    chk("midrst_par", 16'(parity), 16'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_an", 16'(an), 16'hFE);
    chk("post_rst_seg", 16'(dec_ddp), 16'h03);

    // Back-to-back valids: hb toggles twice back to 0
    data_valid = 1'b1; data = 16'h0001;
    tick();
    data = 16'h0003;
    tick();
    data_valid = 1'b0;
    chk("par_b2b", 16'(parity), 16'h0);
    chk_slot(0, 8'h0D);
`ifdef DM_LEADING_ZERO_BLANK_EN
    chk_blank(1);
`else
    chk_slot(1, 8'h03);
`endif

    // Leading zeros, other glyphs (modules/prog sampled live)
    modules = 2'd2; prog = 3'd7;
    capture(16'h0040);
    chk("par_0040", 16'(parity), 16'h1);
    chk_slot(0, 8'h02);
    chk_slot(1, 8'h99);
`ifdef DM_LEADING_ZERO_BLANK_EN
    chk_blank(2);
    chk_blank(3);
`else
    chk_slot(2, 8'h03);
    chk_slot(3, 8'h03);
`endif
    chk_slot(5, 8'hE1);
    chk_slot(7, 8'h1F);

    modules = 2'd3; prog = 3'd0;
    capture(16'h0000);
    chk_slot(0, 8'h03);
`ifdef DM_LEADING_ZERO_BLANK_EN
    chk_blank(1);
    chk_blank(2);
    chk_blank(3);
`else
    chk_slot(1, 8'h03);
    chk_slot(2, 8'h03);
    chk_slot(3, 8'h03);
`endif
    chk_slot(5, 8'hFD);
    chk_slot(7, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/display_mux.md
# display_mux

Output stage of the T3 datapath, directly downstream of the buffering wrapper. Captures each 16-bit word the buffer presents with `data_valid` and holds it until the next valid word. Time-multiplexes eight active-low 7-segment digits: the held word in hex, a source-module glyph, and the current clock-program setting. Also drives the even-parity bit of the held word and a per-word heartbeat on a decimal point.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000. Number of `clk` cycles each digit stays selected. Legal range is 2..2^20.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `data_valid`  in  1  one-cycle qualifier for `data`
- `data`  in  16  word from the buffer
- `modules`  in  2  source selector: 0 = none, 1 = fibonacci, 2 = timer, 3 = none
- `prog`  in  3  current DCM program, 0..7
- `an`  out  8  digit enables, active-low, one-hot-low; bit i selects digit i
- `dec_ddp`  out  8  segments, active-low: [7]=a, [6]=b, [5]=c, [4]=d, [3]=e, [2]=f, [1]=g, [0]=dp
- `parity`  out  1  XOR of all bits of the held word

## Operation
- **Capture.**
  - On a `clk` edge with `data_valid`=1, `held` <= `data` and `parity` <= ^`data`.
  - `held` and `parity` otherwise keep their value.
  - Back-to-back valids are all accepted; the last one wins.
- **Heartbeat.** `hb` toggles on every accepted word. It drives the dp of digit 0: dp lit when `hb`=1. The dp is off on all other digits.
- **Scan.**
  - `div` counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, `idx` (3 bits) increments, 7 wraps to 0.
- **Digit map.**
  - Digits 0..3: hex nibbles `held[3:0]` .. `held[15:12]`.
  - Digit 4: blank.
  - Digit 5: glyph for `modules`: 1 -> 'F' (0x71), 2 -> 't' (d,e,f,g: 0xE1), 0 or 3 -> '-' (0xFD).
  - Digit 6: blank.
  - Digit 7: `prog` as decimal digit 0..7.
- **Blank digit.** `an` = 0xFF and `dec_ddp` = 0xFF for that scan slot.
- **Hex encoding** (dp off): 0=0x03, 1=0x9F, 2=0x25, 3=0x0D, 4=0x99, 5=0x49, 6=0x41, 7=0x1F, 8=0x01, 9=0x09, A=0x11, b=0xC1, C=0x63, d=0x85, E=0x61, F=0x71. A lit dp clears bit 0.
- `modules` and `prog` are sampled live each cycle, not latched.

## Timing
- **Reset values:** `held`=0, `parity`=0, `hb`=0, `div`=0, `idx`=0, `an`=0xFF, `dec_ddp`=0xFF.
- `an`/`dec_ddp` are registered.
  - Each cycle they reflect `idx` and held/live inputs as they stood at the previous edge.
  - The first digit-0 drive appears one cycle after `rst` deasserts.
- **Word latency:** `data_valid` sampled at edge k.
  - `parity` valid after edge k.
  - Segments show the new word from edge k+1 whenever its digit is selected.
- An `idx` change appears on `an` one cycle after the `div` wrap.
- Each digit is selected for exactly REFRESH_DIV cycles. The full frame is 8*REFRESH_DIV cycles.
- **Reset mid-scan:** returns immediately to reset values. The held word is lost.
- `data_valid` coincident with `rst`: ignored.

## Configuration
- **`DM_LEADING_ZERO_BLANK_EN` defined:**
  - Digits 3, 2, 1 are blanked while they and all higher data digits are zero.
  - Digit 0 is never blanked.
  - A blanked data digit behaves as a blank slot (`an`=0xFF, `dec_ddp`=0xFF).
- **Not defined:** all four data digits are always displayed, zeros included.

## Test plan
- **Reset outputs:** hold `rst` 3 cycles -> `an`=0xFF, `dec_ddp`=0xFF, `parity`=0. One cycle after release -> `an`=0xFE, `dec_ddp`=0x03.
- **Capture and parity:** REFRESH_DIV=4, one-cycle `data_valid` with `data`=0x1A2F, `modules`=1, `prog`=5.
  - `parity`=0.
  - Slot 0 -> `dec_ddp`=0x70 (F with dp, `hb`=1).
  - Slots 1..3 -> 0x25, 0x11, 0x9F.
  - Slot 5 -> 0x71; slot 7 -> 0x49.
  - Slots 4/6 -> `an`=0xFF.
- **Back-to-back valids:** 0x0001 then 0x0003 on consecutive cycles -> held=0x0003, `parity`=0, `hb`=0 (two toggles). Slot 0 -> 0x0D.
- **Scan period:** REFRESH_DIV=4 -> each `an` value is held exactly 4 cycles. Sequence is FE, FD, FB, F7, FF, DF, FF, 7F, then repeats.
- **Leading-zero build:** build with `DM_LEADING_ZERO_BLANK_EN`, `data`=0x0040.
  - Slots 3, 2 -> `an`=0xFF.
  - Slot 1 -> 0x99.
  - Slot 0 -> 0x02 (0 with dp).
  - With `data`=0x0000, only slot 0 is lit.
- **Reset mid-operation:** assert `rst` while `idx`=3 with held=0xBEEF -> the next cycle gives `an`=0xFF. After release, slot 0 shows 0x03 and `parity`=0.
